piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter: WIDTH, default 8, data word width in bits; legal range 2..16.
REQ-002 Parameter: MSB_FIRST, default 1; 1 = din[WIDTH-1] shifted first, 0 = din[0] shifted first.
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: din  input  WIDTH  parallel word to serialize.
REQ-006 Port: din_valid  input  1  din holds a word to send.
REQ-007 Port: din_ready  output  1  block accepts din this cycle.
REQ-008 Port: ser_out  output  1  serial bit stream to the downstream sequence detector.
REQ-009 Port: ser_valid  output  1  ser_out carries a frame bit this cycle.
REQ-010 Port: frame_done  output  1  one-cycle pulse marking the final bit of a frame.

Function
REQ-011 Handshake: a word is accepted on a rising edge where din_valid=1 and din_ready=1; din is sampled only then.
REQ-012 States: IDLE, SHIFT, and PARITY (PARITY only when PARITY_EN is defined).
REQ-013 IDLE: din_ready=1, ser_valid=0, ser_out=0, frame_done=0.
REQ-014 IDLE->SHIFT on accept; bit counter cleared; word loaded into the shift register.
REQ-015 Latency: for a word accepted at edge k, frame bit i (i=0..WIDTH-1, order set by MSB_FIRST) is on ser_out with ser_valid=1 during cycle k+1+i.
REQ-016 ser_out, ser_valid and frame_done are registered outputs; din_ready is decoded combinationally from state and bit counter only, never from din_valid.
REQ-017 din_ready=1 during IDLE and during the cycle that presents the final bit of a frame; 0 in all other cycles.
REQ-018 Back-to-back: accepting during the final-bit cycle loads the next word, so its first bit follows with no gap and ser_valid stays 1.
REQ-019 No accept during the final-bit cycle: next state is IDLE, and ser_valid=0 in the following cycle.
REQ-020 frame_done=1 exactly in the final-bit cycle of each frame, including back-to-back frames.
REQ-021 din_valid is ignored while din_ready=0; changes to din mid-frame do not affect the frame in flight.
REQ-022 Bit counter width is ceil(log2(WIDTH+1)); it does not wrap mid-frame and is cleared on every load.

Reset
REQ-023 While reset=1 at a rising edge: state<=IDLE, counter<=0, shift register<=0, ser_out<=0, ser_valid<=0, frame_done<=0.
REQ-024 Reset has priority over a simultaneous handshake; that word is dropped.
REQ-025 Reset mid-frame aborts the frame; no remaining bits are emitted; din_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-026 Macro PISO_PARITY_EN: when defined, each frame is WIDTH+1 bits; after the data bits, PARITY presents the even-parity bit (XOR of all WIDTH data bits) with ser_valid=1.
REQ-027 With PISO_PARITY_EN defined, the parity cycle is the final-bit cycle for REQ-017, REQ-018 and REQ-020.
REQ-028 Without PISO_PARITY_EN, no PARITY state or parity logic exists and each frame is exactly WIDTH bits.

Verification
REQ-029 Defaults, reset, then din=8'hAA accepted at edge k: ser_out=1,0,1,0,1,0,1,0 in cycles k+1..k+8; ser_valid=1 for those 8 cycles only; frame_done=1 only in cycle k+8.
REQ-030 din_valid held high with 8'hA5 then 8'h0F: 16 contiguous ser_valid cycles carrying 1010_0101_0000_1111; frame_done pulses in cycles k+8 and k+16.
REQ-031 MSB_FIRST=0, din=8'h01: ser_out=1 in cycle k+1, then 0 for cycles k+2..k+8.
REQ-032 Reset asserted during the 4th bit of 8'hFF: next cycle ser_valid=0 and ser_out=0; after release, din_ready=1 and a new word 8'h0A serializes correctly.
REQ-033 PISO_PARITY_EN defined, din=8'h07: 8 data bits, then parity bit 1 in cycle k+9 with frame_done=1; din=8'h03 gives parity 0.
REQ-034 din_valid pulsed while din_ready=0 mid-frame: the pulse is ignored, the current frame is unchanged, and no extra frame is emitted.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out framer with valid/ready intake.
// A word accepted on din is emitted one bit per cycle on ser_out, in MSB-first
// or LSB-first order, with ser_valid high for every frame bit and frame_done
// marking the last bit. din_ready reopens in the final-bit cycle so frames can
// run back-to-back with no gap.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit to
// every frame (frames become WIDTH+1 bits long).
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;      // index of the data bit currently on ser_out
    logic [WIDTH-1:0] sr_q, sr_d;        // bits still to be sent, next one at the shift end
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             frame_done_q, frame_done_d;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;      // even parity of the word in flight
`endif

    logic             accept;
    logic [CNT_W-1:0] cnt_nxt;

    // Ready depends only on state and bit counter, so it never loops back from din_valid.
    always_comb begin
        din_ready = 1'b0;
        case (state_q)
            IDLE:    din_ready = 1'b1;
`ifdef PISO_PARITY_EN
            PARITY:  din_ready = 1'b1;
`else
            SHIFT:   din_ready = (cnt_q == LAST);
`endif
            default: din_ready = 1'b0;
        endcase
    end

    assign accept  = din_valid && din_ready;
    assign cnt_nxt = cnt_q + CNT_W'(1);

    // Next-state and next-output decode; an accepted word always wins and reloads everything.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sr_d         = sr_q;
        ser_out_d    = 1'b0;
        ser_valid_d  = 1'b0;
        frame_done_d = 1'b0;
`ifdef PISO_PARITY_EN
        par_d        = par_q;
`endif
        if (accept) begin
            state_d     = SHIFT;
            cnt_d       = '0;
            ser_valid_d = 1'b1;
            if (MSB_FIRST != 0) begin
                ser_out_d = din[WIDTH-1];
                sr_d      = {din[WIDTH-2:0], 1'b0};
            end else begin
                ser_out_d = din[0];
                sr_d      = {1'b0, din[WIDTH-1:1]};
            end
`ifdef PISO_PARITY_EN
            par_d = ^din;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    if (cnt_q != LAST) begin
                        cnt_d       = cnt_nxt;
                        ser_valid_d = 1'b1;
                        if (MSB_FIRST != 0) begin
                            ser_out_d = sr_q[WIDTH-1];
                            sr_d      = {sr_q[WIDTH-2:0], 1'b0};
                        end else begin
                            ser_out_d = sr_q[0];
                            sr_d      = {1'b0, sr_q[WIDTH-1:1]};
                        end
`ifndef PISO_PARITY_EN
                        frame_done_d = (cnt_nxt == LAST);
`endif
                    end else begin
`ifdef PISO_PARITY_EN
                        state_d      = PARITY;
                        ser_out_d    = par_q;
                        ser_valid_d  = 1'b1;
                        frame_done_d = 1'b1;
`else
                        state_d = IDLE;
`endif
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY:  state_d = IDLE;
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // State and registered outputs; reset overrides any simultaneous handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sr_q         <= '0;
            ser_out_q    <= 1'b0;
            ser_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            ser_out_q    <= ser_out_d;
            ser_valid_q  <= ser_valid_d;
            frame_done_q <= frame_done_d;
`ifdef PISO_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    assign ser_out    = ser_out_q;
    assign ser_valid  = ser_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed, table-driven bench for piso_serializer.
// Two instances: u_msb (defaults) and u_lsb (MSB_FIRST=0). Each table row is
// one clock cycle: the outputs expected during that cycle and the inputs
// driven in it. Multi-cycle corner cases (reset abort, LSB order, parity)
// are hand-written sequences.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] m_din, l_din;
    logic       m_valid, l_valid;
    logic       m_ready, m_so, m_sv, m_fd;
    logic       l_ready, l_so, l_sv, l_fd;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    piso_serializer u_msb (
        .clk(clk), .reset(reset), .din(m_din), .din_valid(m_valid),
        .din_ready(m_ready), .ser_out(m_so), .ser_valid(m_sv), .frame_done(m_fd)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .din(l_din), .din_valid(l_valid),
        .din_ready(l_ready), .ser_out(l_so), .ser_valid(l_sv), .frame_done(l_fd)
    );

    typedef struct {
        logic [7:0] din;
        logic       vld;
        logic       so;
        logic       sv;
        logic       fd;
        logic       rdy;
    } vec_t;

    vec_t tbl[$];

`ifdef PISO_PARITY_EN
    localparam int LASTI = 8;
`else
    localparam int LASTI = 7;
`endif

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic add_idle(input logic [7:0] din, input logic vld);
        vec_t v;
        v.din = din; v.vld = vld; v.so = 1'b0; v.sv = 1'b0; v.fd = 1'b0; v.rdy = 1'b1;
        tbl.push_back(v);
    endtask

    // bits: frame bits in serial order, bits[7] first; par: hand-computed parity bit.
    task automatic add_frame(input logic [7:0] bits, input logic par, input logic [7:0] mid_mask,
                             input logic last_vld, input logic [7:0] din);
        vec_t v;
        for (int i = 0; i <= LASTI; i++) begin
            v.din = din;
            v.vld = (i == LASTI) ? last_vld : mid_mask[i];
            v.so  = (i < 8) ? bits[7-i] : par;
            v.sv  = 1'b1;
            v.fd  = (i == LASTI);
            v.rdy = (i == LASTI);
            tbl.push_back(v);
        end
    endtask

    // Checks a frame accepted at the previous edge, then the idle cycle after it.
    task automatic run_frame(input string nm, input logic lsb, input logic [7:0] bits, input logic par);
        logic so, sv, fd, rdy;
        for (int i = 0; i <= LASTI + 1; i++) begin
            so  = lsb ? l_so : m_so;
            sv  = lsb ? l_sv : m_sv;
            fd  = lsb ? l_fd : m_fd;
            rdy = lsb ? l_ready : m_ready;
            if (i <= LASTI) begin
                chk($sformatf("%s bit%0d ser_out", nm, i), so, (i < 8) ? bits[7-i] : par);
                chk($sformatf("%s bit%0d ser_valid", nm, i), sv, 1'b1);
                chk($sformatf("%s bit%0d frame_done", nm, i), fd, i == LASTI);
                chk($sformatf("%s bit%0d din_ready", nm, i), rdy, i == LASTI);
                cyc();
            end else begin
                chk($sformatf("%s idle ser_valid", nm), sv, 1'b0);
                chk($sformatf("%s idle ser_out", nm), so, 1'b0);
                chk($sformatf("%s idle frame_done", nm), fd, 1'b0);
                chk($sformatf("%s idle din_ready", nm), rdy, 1'b1);
            end
        end
    endtask

    initial begin
        // Single frame AA, back-to-back A5 -> 0F with din changing mid-frame,
        // then 3C with a stray valid pulse while not ready.
        add_idle(8'hAA, 1'b1);
        add_frame(8'b1010_1010, 1'b0, 8'h00, 1'b0, 8'h00);
        add_idle(8'hA5, 1'b1);
        add_frame(8'b1010_0101, 1'b0, 8'hFF, 1'b1, 8'h0F);
        add_frame(8'b0000_1111, 1'b0, 8'h00, 1'b0, 8'h00);
        add_idle(8'h3C, 1'b1);
        add_frame(8'b0011_1100, 1'b0, 8'h04, 1'b0, 8'hFF);
        add_idle(8'h00, 1'b0);
        add_idle(8'h00, 1'b0);

        reset = 1'b1; m_din = '0; m_valid = 1'b0; l_din = '0; l_valid = 1'b0;
        cyc();
        cyc();
        chk("reset ser_out", m_so, 1'b0);
        chk("reset ser_valid", m_sv, 1'b0);
        chk("reset frame_done", m_fd, 1'b0);
        chk("reset din_ready", m_ready, 1'b1);
        reset = 1'b0;

        // Table: check this cycle's outputs, then drive this cycle's inputs.
        for (int j = 0; j < tbl.size(); j++) begin
            chk($sformatf("row%0d ser_out", j), m_so, tbl[j].so);
            chk($sformatf("row%0d ser_valid", j), m_sv, tbl[j].sv);
            chk($sformatf("row%0d frame_done", j), m_fd, tbl[j].fd);
            chk($sformatf("row%0d din_ready", j), m_ready, tbl[j].rdy);
            m_din   = tbl[j].din;
            m_valid = tbl[j].vld;
            cyc();
        end
        m_valid = 1'b0;

        // LSB-first order: 01 -> 1 then seven 0s (parity of 01 is 1).
        l_din = 8'h01; l_valid = 1'b1;
        cyc();
        l_valid = 1'b0;
        run_frame("lsb01", 1'b1, 8'b1000_0000, 1'b1);

        // Reset during the 4th bit of FF aborts the frame.
        m_din = 8'hFF; m_valid = 1'b1;
        cyc();
        m_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("abort bit%0d ser_out", i), m_so, 1'b1);
            chk($sformatf("abort bit%0d ser_valid", i), m_sv, 1'b1);
            if (i < 3) cyc();
        end
        reset = 1'b1;
        cyc();
        chk("abort after ser_valid", m_sv, 1'b0);
        chk("abort after ser_out", m_so, 1'b0);
        chk("abort after frame_done", m_fd, 1'b0);
        chk("abort after din_ready", m_ready, 1'b1);
        // Handshake under reset is dropped.
        m_din = 8'h55; m_valid = 1'b1;
        cyc();
        reset = 1'b0; m_valid = 1'b0;
        chk("rst-hs ser_valid", m_sv, 1'b0);
        chk("rst-hs din_ready", m_ready, 1'b1);
        cyc();
        chk("rst-hs dropped ser_valid", m_sv, 1'b0);
        chk("rst-hs dropped ser_out", m_so, 1'b0);
        m_din = 8'h0A; m_valid = 1'b1;
        cyc();
        m_valid = 1'b0;
        run_frame("post-rst 0A", 1'b0, 8'b0000_1010, 1'b0);

`ifdef PISO_PARITY_EN
        m_din = 8'h07; m_valid = 1'b1;
        cyc();
        m_valid = 1'b0;
        run_frame("par07", 1'b0, 8'b0000_0111, 1'b1);
        m_din = 8'h03; m_valid = 1'b1;
        cyc();
        m_valid = 1'b0;
        run_frame("par03", 1'b0, 8'b0000_0011, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
